// File: rtl/vga_timing_gen_if.sv
// ============================================================================
//  Module  : vga_timing_gen_if
//  Brief   : Video source bundle: pattern controls in, DVI-ready raster out.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface vga_timing_gen_if;
    logic [1:0]  pattern_sel;
    logic [23:0] solid_rgb;
    logic [23:0] rgb_data;
    logic        hs;
    logic        vs;
    logic        de;
    logic [11:0] x;
    logic [11:0] y;
    logic        frame_start;

    // master = timing generator, slave = DVI serialiser side
    modport master (
        input  pattern_sel, solid_rgb,
        output rgb_data, hs, vs, de, x, y, frame_start
    );

    modport slave (
        output pattern_sel, solid_rgb,
        input  rgb_data, hs, vs, de, x, y, frame_start
    );
endinterface

`default_nettype wire

// File: rtl/vga_timing_gen.sv
// ============================================================================
//  Module  : vga_timing_gen
//  Brief   : Raster timing (hs/vs/de), pixel coordinates and test patterns.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input  wire logic        pix_clk,
    input  wire logic        rst_n,
    vga_timing_gen_if.master vid
);

    localparam logic [11:0] c_h_active = 12'(H_ACTIVE);
    localparam logic [11:0] c_h_last   = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [11:0] c_hs_start = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] c_hs_end   = 12'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [11:0] c_v_active = 12'(V_ACTIVE);
    localparam logic [11:0] c_v_last   = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [11:0] c_vs_start = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] c_vs_end   = 12'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [11:0] c_bar_last = 12'(H_ACTIVE / 8 - 1);

    logic [11:0] r_h_cnt;
    logic [11:0] r_v_cnt;
    logic [11:0] r_bar_sub;
    logic [2:0]  r_bar_idx;
    logic [1:0]  r_pattern;

    logic        w_h_wrap;
    logic        w_v_wrap;
    logic        w_origin;
    logic        w_de;
    logic        w_hs;
    logic        w_vs;
    logic [1:0]  w_pat;
    logic [7:0]  w_sum;
    logic [23:0] w_bar_rgb;
    logic [23:0] w_pat_rgb;

    assign w_h_wrap = (r_h_cnt == c_h_last);
    assign w_v_wrap = (r_v_cnt == c_v_last);
    assign w_origin = (r_h_cnt == 12'd0) && (r_v_cnt == 12'd0);
    assign w_de     = (r_h_cnt < c_h_active) && (r_v_cnt < c_v_active);
    assign w_hs     = (r_h_cnt >= c_hs_start) && (r_h_cnt <= c_hs_end);
    assign w_vs     = (r_v_cnt >= c_vs_start) && (r_v_cnt <= c_vs_end);
    assign w_sum    = r_h_cnt[7:0] + r_v_cnt[7:0];

    // The origin pixel already uses the newly selected pattern, so a frame is never split.
    assign w_pat    = w_origin ? vid.pattern_sel : r_pattern;

    always_comb begin
        w_bar_rgb = 24'h000000;
        case (r_bar_idx)
            3'd0:    w_bar_rgb = 24'hFFFFFF;
            3'd1:    w_bar_rgb = 24'hFFFF00;
            3'd2:    w_bar_rgb = 24'h00FFFF;
            3'd3:    w_bar_rgb = 24'h00FF00;
            3'd4:    w_bar_rgb = 24'hFF00FF;
            3'd5:    w_bar_rgb = 24'hFF0000;
            3'd6:    w_bar_rgb = 24'h0000FF;
            default: w_bar_rgb = 24'h000000;
        endcase
    end

    always_comb begin
        w_pat_rgb = 24'h000000;
        case (w_pat)
            2'd0:    w_pat_rgb = w_bar_rgb;
            2'd1:    w_pat_rgb = ((r_h_cnt[4:0] == 5'd0) || (r_v_cnt[4:0] == 5'd0))
                                 ? 24'hFFFFFF : 24'h000000;
            2'd2:    w_pat_rgb = {r_h_cnt[7:0], r_v_cnt[7:0], w_sum};
            default: w_pat_rgb = vid.solid_rgb;
        endcase
    end

    always_ff @(posedge pix_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h_cnt         <= 12'd0;
            r_v_cnt         <= 12'd0;
            r_bar_sub       <= 12'd0;
            r_bar_idx       <= 3'd0;
            r_pattern       <= 2'd0;
            vid.hs          <= ~HS_POL;
            vid.vs          <= ~VS_POL;
            vid.de          <= 1'b0;
            vid.rgb_data    <= 24'h000000;
            vid.x           <= 12'd0;
            vid.y           <= 12'd0;
            vid.frame_start <= 1'b0;
        end else begin
            if (w_h_wrap) begin
                r_h_cnt <= 12'd0;
                r_v_cnt <= w_v_wrap ? 12'd0 : r_v_cnt + 12'd1;
            end else begin
                r_h_cnt <= r_h_cnt + 12'd1;
            end

            // Bar index tracks h_cnt in BAR_W steps without a divider.
            if (w_h_wrap) begin
                r_bar_sub <= 12'd0;
                r_bar_idx <= 3'd0;
            end else if (r_bar_sub == c_bar_last) begin
                r_bar_sub <= 12'd0;
                r_bar_idx <= r_bar_idx + 3'd1;
            end else begin
                r_bar_sub <= r_bar_sub + 12'd1;
            end

            if (w_origin) begin
                r_pattern <= vid.pattern_sel;
            end

            vid.hs          <= w_hs ? HS_POL : ~HS_POL;
            vid.vs          <= w_vs ? VS_POL : ~VS_POL;
            vid.de          <= w_de;
            vid.rgb_data    <= w_de ? w_pat_rgb : 24'h000000;
            vid.x           <= r_h_cnt;
            vid.y           <= r_v_cnt;
            vid.frame_start <= w_origin;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
// ============================================================================
//  Module  : tb_vga_timing_gen
//  Brief   : Self-checking bench for vga_timing_gen on a 24x8 raster.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_timing_gen;

    localparam int H_A = 16, H_F = 2, H_S = 3, H_B = 3;
    localparam int V_A = 4,  V_F = 1, V_S = 1, V_B = 2;
    localparam int H_T = H_A + H_F + H_S + H_B;
    localparam int V_T = V_A + V_F + V_S + V_B;
    localparam int F_T = H_T * V_T;

    typedef struct packed {
        logic        de;
        logic        hs;
        logic        vs;
        logic        fs;
        logic [11:0] x;
        logic [11:0] y;
        logic [23:0] rgb;
    } exp_t;

    logic pix_clk = 1'b0;
    logic rst_n   = 1'b0;

    int checks   = 0;
    int failures = 0;
    int m_pos    = 0;   // raster position the next edge will register
    int m_last   = 0;   // position registered by the most recent edge
    int m_cyc    = 0;   // edges since reset release
    logic [1:0] m_pat = 2'd0;

    vga_timing_gen_if vif ();

    vga_timing_gen #(
        .H_ACTIVE(H_A), .H_FP(H_F), .H_SYNC(H_S), .H_BP(H_B),
        .V_ACTIVE(V_A), .V_FP(V_F), .V_SYNC(V_S), .V_BP(V_B),
        .HS_POL(1'b0),  .VS_POL(1'b0)
    ) u_dut (
        .pix_clk (pix_clk),
        .rst_n   (rst_n),
        .vid     (vif)
    );

    always #5 pix_clk = ~pix_clk;

    function automatic logic [23:0] ref_rgb(int h, int v, logic [1:0] pat, logic [23:0] solid);
        logic [23:0] c;
        c = 24'h0;
        case (pat)
            2'd0: case (h / (H_A / 8))
                      0: c = 24'hFFFFFF; 1: c = 24'hFFFF00; 2: c = 24'h00FFFF; 3: c = 24'h00FF00;
                      4: c = 24'hFF00FF; 5: c = 24'hFF0000; 6: c = 24'h0000FF; default: c = 24'h0;
                  endcase
            2'd1: c = ((h % 32 == 0) || (v % 32 == 0)) ? 24'hFFFFFF : 24'h0;
            2'd2: c = {8'(h), 8'(v), 8'(h + v)};
            default: c = solid;
        endcase
        return c;
    endfunction

    // Advance one pixel clock and return what the raster rules say must appear.
    task automatic step(output exp_t e);
        int h, v;
        @(posedge pix_clk);
        m_last = m_pos;
        h = m_pos % H_T;
        v = m_pos / H_T;
        if (m_pos == 0) m_pat = vif.pattern_sel;
        e.de  = (h < H_A) && (v < V_A);
        e.hs  = !((h >= H_A + H_F) && (h < H_A + H_F + H_S));
        e.vs  = !((v >= V_A + V_F) && (v < V_A + V_F + V_S));
        e.fs  = (m_pos == 0);
        e.x   = 12'(h);
        e.y   = 12'(v);
        e.rgb = e.de ? ref_rgb(h, v, m_pat, vif.solid_rgb) : 24'h0;
        m_pos = (m_pos + 1) % F_T;
        m_cyc++;
        #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge pix_clk);
        #1;
        checks++;
        if (vif.de !== 1'b0 || vif.hs !== 1'b1 || vif.vs !== 1'b1 || vif.frame_start !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl: de=%b hs=%b vs=%b fs=%b, need 0 1 1 0",
                     vif.de, vif.hs, vif.vs, vif.frame_start);
        end
        checks++;
        if (vif.rgb_data !== 24'h0 || vif.x !== 12'd0 || vif.y !== 12'd0) begin
            failures++;
            $display("FAIL reset_data: rgb=%h x=%0d y=%0d, need 0 0 0", vif.rgb_data, vif.x, vif.y);
        end
        rst_n = 1'b1;
        m_pos = 0;
        m_cyc = 0;
        m_pat = 2'd0;
    endtask

    task automatic test_raster();
        exp_t e;
        int de_cnt;
        int fs_cyc [$];
        vif.pattern_sel = 2'd0;
        for (int f = 0; f < 2; f++) begin
            de_cnt = 0;
            for (int i = 0; i < F_T; i++) begin
                step(e);
                if (vif.de === 1'b1) de_cnt++;
                if (vif.frame_start === 1'b1) fs_cyc.push_back(m_cyc);
                checks++;
                if (vif.de !== e.de || vif.frame_start !== e.fs) begin
                    failures++;
                    $display("FAIL raster_de pos=%0d: de=%b fs=%b, need %b %b",
                             m_last, vif.de, vif.frame_start, e.de, e.fs);
                end
                if (e.de) begin
                    checks++;
                    if (vif.x !== e.x || vif.y !== e.y || vif.rgb_data !== e.rgb) begin
                        failures++;
                        $display("FAIL raster_xy pos=%0d: x=%0d y=%0d rgb=%h, need %0d %0d %h",
                                 m_last, vif.x, vif.y, vif.rgb_data, e.x, e.y, e.rgb);
                    end
                end
            end
            checks++;
            if (de_cnt != 64) begin
                failures++;
                $display("FAIL de_per_frame: got %0d, need 64", de_cnt);
            end
        end
        checks++;
        if (fs_cyc.size() != 2 || fs_cyc[0] != 1 || fs_cyc[1] != 193) begin
            failures++;
            $display("FAIL frame_start_cycles: count=%0d first=%0d, need 2 at 1 and 193",
                     fs_cyc.size(), (fs_cyc.size() > 0) ? fs_cyc[0] : -1);
        end
    endtask

    task automatic test_hsync();
        exp_t e;
        int low_cnt, first_h;
        for (int l = 0; l < V_T; l++) begin
            low_cnt = 0;
            first_h = -1;
            for (int h = 0; h < H_T; h++) begin
                step(e);
                if (vif.hs === 1'b0) begin
                    low_cnt++;
                    if (first_h < 0) first_h = h;
                end
                checks++;
                if (vif.hs !== e.hs) begin
                    failures++;
                    $display("FAIL hs_level line=%0d h=%0d: got %b, need %b", l, h, vif.hs, e.hs);
                end
            end
            checks++;
            if (low_cnt != 3 || first_h != 18) begin
                failures++;
                $display("FAIL hs_width line=%0d: low=%0d start=%0d, need 3 at 18", l, low_cnt, first_h);
            end
        end
    endtask

    task automatic test_vsync();
        exp_t e;
        int run, start, stop;
        run = 0; start = -1; stop = -1;
        for (int i = 0; i < F_T; i++) begin
            step(e);
            if (vif.vs === 1'b0) begin
                run++;
                if (start < 0) start = m_last;
            end else if (start >= 0 && stop < 0) begin
                stop = m_last;
            end
            checks++;
            if (vif.vs !== e.vs) begin
                failures++;
                $display("FAIL vs_level pos=%0d: got %b, need %b", m_last, vif.vs, e.vs);
            end
        end
        checks++;
        if (run != 24 || start != 5 * H_T || stop != 6 * H_T) begin
            failures++;
            $display("FAIL vs_window: run=%0d start=%0d stop=%0d, need 24 120 144", run, start, stop);
        end
    endtask

    task automatic test_bars();
        exp_t e;
        logic [23:0] bars [8];
        bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
        vif.pattern_sel = 2'd0;
        vif.solid_rgb   = 24'hA5A5A5;
        for (int i = 0; i < F_T; i++) begin
            step(e);
            checks++;
            if (e.de) begin
                if (vif.rgb_data !== bars[(m_last % H_T) / 2]) begin
                    failures++;
                    $display("FAIL bar_colour x=%0d: got %h, need %h",
                             m_last % H_T, vif.rgb_data, bars[(m_last % H_T) / 2]);
                end
            end else if (vif.rgb_data !== 24'h0) begin
                failures++;
                $display("FAIL bar_blank pos=%0d: got %h, need 000000", m_last, vif.rgb_data);
            end
        end
    endtask

    task automatic test_gradient_switch();
        exp_t e;
        int h, v;
        vif.pattern_sel = 2'd2;
        vif.solid_rgb   = 24'h0;
        for (int i = 0; i < F_T; i++) begin
            step(e);
            h = m_last % H_T;
            v = m_last / H_T;
            if (m_last == H_T + 6) begin
                vif.pattern_sel = 2'd3;
                vif.solid_rgb   = 24'h123456;
            end
            if (e.de) begin
                checks++;
                if (vif.rgb_data !== {8'(h), 8'(v), 8'(h + v)}) begin
                    failures++;
                    $display("FAIL gradient x=%0d y=%0d: got %h, need %h",
                             h, v, vif.rgb_data, {8'(h), 8'(v), 8'(h + v)});
                end
            end
            if (h == 3 && v == 2) begin
                checks++;
                if (vif.rgb_data !== 24'h030205) begin
                    failures++;
                    $display("FAIL gradient_3_2: got %h, need 030205", vif.rgb_data);
                end
            end
        end
        for (int i = 0; i < F_T; i++) begin
            step(e);
            if (e.de) begin
                checks++;
                if (vif.rgb_data !== 24'h123456) begin
                    failures++;
                    $display("FAIL solid pos=%0d: got %h, need 123456", m_last, vif.rgb_data);
                end
            end
        end
    endtask

    task automatic test_random();
        exp_t e;
        for (int i = 0; i < 3 * F_T; i++) begin
            step(e);
            checks++;
            if (vif.de !== e.de || vif.hs !== e.hs || vif.vs !== e.vs ||
                vif.frame_start !== e.fs || vif.rgb_data !== e.rgb ||
                (e.de && (vif.x !== e.x || vif.y !== e.y))) begin
                failures++;
                $display("FAIL random pos=%0d: de%b hs%b vs%b fs%b x%0d y%0d rgb=%h, need de%b hs%b vs%b fs%b x%0d y%0d rgb=%h",
                         m_last, vif.de, vif.hs, vif.vs, vif.frame_start, vif.x, vif.y, vif.rgb_data,
                         e.de, e.hs, e.vs, e.fs, e.x, e.y, e.rgb);
            end
            if ($urandom_range(0, 15) == 0) vif.pattern_sel = 2'($urandom_range(0, 3));
            vif.solid_rgb = 24'($urandom);
        end
    endtask

    task automatic test_midreset();
        exp_t e;
        vif.pattern_sel = 2'd2;
        for (int i = 0; i < H_T + 7; i++) step(e);
        rst_n = 1'b0;
        #1;
        for (int c = 0; c < 6; c++) begin
            checks++;
            if (vif.de !== 1'b0 || vif.hs !== 1'b1 || vif.vs !== 1'b1 ||
                vif.rgb_data !== 24'h0 || vif.frame_start !== 1'b0) begin
                failures++;
                $display("FAIL midreset_hold c=%0d: de=%b hs=%b vs=%b rgb=%h fs=%b, need 0 1 1 000000 0",
                         c, vif.de, vif.hs, vif.vs, vif.rgb_data, vif.frame_start);
            end
            if (c < 5) begin
                @(posedge pix_clk);
                #1;
            end
        end
        rst_n = 1'b1;
        m_pos = 0;
        m_pat = 2'd0;
        step(e);
        checks++;
        if (vif.de !== 1'b1 || vif.x !== 12'd0 || vif.y !== 12'd0 || vif.frame_start !== 1'b1) begin
            failures++;
            $display("FAIL midreset_restart: de=%b x=%0d y=%0d fs=%b, need 1 0 0 1",
                     vif.de, vif.x, vif.y, vif.frame_start);
        end
        for (int i = 0; i < H_T; i++) begin
            step(e);
            checks++;
            if (vif.de !== e.de || vif.hs !== e.hs || vif.rgb_data !== e.rgb) begin
                failures++;
                $display("FAIL midreset_line pos=%0d: de=%b hs=%b rgb=%h, need %b %b %h",
                         m_last, vif.de, vif.hs, vif.rgb_data, e.de, e.hs, e.rgb);
            end
        end
    endtask

    initial begin
        vif.pattern_sel = 2'd0;
        vif.solid_rgb   = 24'h0;
        test_reset();
        test_raster();
        test_hsync();
        test_vsync();
        test_bars();
        test_gradient_switch();
        test_random();
        test_midreset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Video source stage that sits directly upstream of the TMDS/DVI output path.
- Generates raster timing (hs, vs, de) and pixel coordinates from the pixel clock.
- Generates a selectable test pattern as 24-bit RGB (R[23:16], G[15:8], B[7:0]).
- Outputs connect directly to the DVI serialiser inputs rgb_data/hs/vs/de.

Parameters:
H_ACTIVE, 640, active pixels per line (must be a multiple of 8)
H_FP, 16, horizontal front porch in pixels
H_SYNC, 96, horizontal sync width in pixels
H_BP, 48, horizontal back porch in pixels
V_ACTIVE, 480, active lines per frame
V_FP, 10, vertical front porch in lines
V_SYNC, 2, vertical sync width in lines
V_BP, 33, vertical back porch in lines
HS_POL, 0, asserted level of hs (0 = active-low)
VS_POL, 0, asserted level of vs (0 = active-low)

Ports:
pix_clk  input  1  pixel clock; the only clock
rst_n  input  1  asynchronous active-low reset
pattern_sel  input  2  0 colour bars, 1 grid, 2 gradient, 3 solid
solid_rgb  input  24  colour used when pattern_sel=3
rgb_data  output  24  pixel colour; 0 whenever de=0
hs  output  1  horizontal sync, polarity per HS_POL
vs  output  1  vertical sync, polarity per VS_POL
de  output  1  active-video enable
x  output  12  horizontal pixel coordinate, valid while de=1
y  output  12  vertical line coordinate, valid while de=1
frame_start  output  1  one-cycle pulse with the first active pixel (0,0) of each frame

Behaviour:
- Interface: one clock, pix_clk; reset rst_n is asynchronous, active-low.
- Reset values:
  - Counters h_cnt=0, v_cnt=0; latched pattern=0.
  - Outputs: hs=~HS_POL, vs=~VS_POL, de=0, rgb_data=0, x=0, y=0, frame_start=0.
- Counters:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL defined the same way.
  - h_cnt counts 0..H_TOTAL-1 every cycle and wraps to 0.
  - v_cnt increments only when h_cnt wraps, and wraps to 0 after V_TOTAL-1.
  - Ordering within a line is active, FP, sync, BP. Frames therefore begin with active video.
- Decode (combinational from the counters):
  - de_c = (h_cnt<H_ACTIVE) && (v_cnt<V_ACTIVE).
  - hs is asserted for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1].
  - vs is asserted for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]. vs changes aligned to the h_cnt wrap.
- Latency and registration:
  - All outputs are registered with 1 cycle of latency from the counter state.
  - hs, vs, de, x, y, rgb_data and frame_start are mutually aligned in the same cycle.
- Startup:
  - The first pix_clk edge after reset release registers the (0,0) decode: de=1, frame_start=1, x=0, y=0.
- frame_start:
  - Pulses when the registered state is h_cnt=0 and v_cnt=0.
  - High for exactly 1 cycle per frame.
- Pattern select:
  - pattern_sel is latched only at h_cnt=0, v_cnt=0, so a pattern change takes effect on the next frame boundary and never mid-frame.
  - solid_rgb is sampled live every cycle.
- Pattern 0, colour bars:
  - 8 bars, each BAR_W = H_ACTIVE/8 pixels wide.
  - Bar order: white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000.
  - Bar index comes from a 3-bit bar counter plus a sub-counter that resets at h_cnt=0. No divider is used.
- Pattern 1, grid: FFFFFF when x[4:0]==0 or y[4:0]==0, otherwise 000000.
- Pattern 2, gradient: R=x[7:0], G=y[7:0], B=(x+y)[7:0] (modulo 256).
- Pattern 3, solid: rgb_data=solid_rgb.
- Blanking: rgb_data=0 whenever registered de=0, regardless of pattern.
- Mid-frame reset:
  - Outputs return to their reset values immediately (asynchronously).
  - The raster restarts at (0,0) on release; no partial-frame recovery.

Test Plan:
Common bench parameters: H_ACTIVE=16, H_FP=2, H_SYNC=3, H_BP=3 (H_TOTAL=24); V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=2 (V_TOTAL=8); HS_POL=VS_POL=0.

1. Release reset, run 2 frames (384 cycles) -> de high 16 of every 24 cycles on lines 0..3 only, giving 64 de cycles per frame; frame_start high exactly at cycle 1 and cycle 193.
2. Horizontal sync -> hs low for exactly 3 cycles per line, starting 18 cycles after de rises (registered h=18..20), in all 8 lines including blanking lines.
3. Vertical sync -> vs low for 24 consecutive cycles, spanning line 5, with its edges coinciding with the registered h=0 of lines 5 and 6.
4. pattern_sel=0 -> x=0,1 give FFFFFF; x=2,3 give FFFF00; and so on through x=14,15 giving 000000. rgb_data=0 while de=0.
5. pattern_sel=2, and switch pattern_sel 2->3 with solid_rgb=123456 at a mid-frame point -> x=3, y=2 gives rgb=030205. The remainder of that frame stays gradient; the next frame is 123456 on every active pixel.
6. Assert rst_n low mid-line for 5 cycles, then release -> de=0, hs=vs=1, rgb=0 during reset; first cycle after release gives de=1, x=0, y=0, frame_start=1.
